one_shot_pulse_rx: RTL and testbench

Receive-side companion to the one-shot pulse generator: measures the high time of an incoming single-cycle-resolution pulse in clock cycles, classifies it against an expected length, and presents the result on a valid/ack handshake. Sits downstream of a pulse source on the same `i_clk` domain; an optional synchronizer front end supports asynchronous sources.

---
 rtl/one_shot_pulse_rx.sv | 160 ++++++++++++++++
 tb/tb_one_shot_pulse_rx.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/one_shot_pulse_rx.sv
// one_shot_pulse_rx: measures the high time of a pulse in i_clk cycles and reports it.
// Latency: o_valid is registered and asserts on the edge that samples the first low level.
//          Defining PULSE_RX_SYNC_EN adds a 2-flop input synchronizer, which adds 2 cycles.
// Backpressure: the result is held until i_ack; rises seen while holding are dropped and flagged on o_drop.
module one_shot_pulse_rx #(
  parameter int p_EXP_LENGTH = 5,
  parameter int p_MAX_LENGTH = 16,
  localparam int CW = $clog2(p_MAX_LENGTH + 1)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_pulse,
  input  logic          i_ack,
  output logic          o_valid,
  output logic [CW-1:0] o_width,
  output logic          o_match,
  output logic          o_ovf,
  output logic          o_busy,
  output logic          o_drop
);

  localparam logic [CW-1:0] MAX_C = CW'(p_MAX_LENGTH);
  localparam logic [CW-1:0] EXP_C = CW'(p_EXP_LENGTH);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_MEASURE  = 2'd1,
    S_OVERFLOW = 2'd2,
    S_REPORT   = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [CW-1:0]   width_q, width_d;
  logic            valid_q, valid_d;
  logic            match_q, match_d;
  logic            ovf_q, ovf_d;
  logic            busy_q, busy_d;
  logic            drop_q, drop_d;
  logic            prev_q;
  logic            pulse_s;
  logic            rise;

`ifdef PULSE_RX_SYNC_EN
  logic sync1_q, sync2_q;

  // Two-flop synchronizer for an asynchronous pulse source.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= i_pulse;
      sync2_q <= sync1_q;
    end
  end

  assign pulse_s = sync2_q;
`else
  assign pulse_s = i_pulse;
`endif

  // Previous-sample register; resets high so a level already high at reset exit is not a rise.
  always_ff @(posedge i_clk) begin
    if (i_rst) prev_q <= 1'b1;
    else       prev_q <= pulse_s;
  end

  assign rise = pulse_s & ~prev_q;

  // Next-state and registered-output computation for the measurement FSM.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    width_d = width_q;
    valid_d = valid_q;
    match_d = match_q;
    ovf_d   = ovf_q;
    drop_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (rise) begin
          state_d = S_MEASURE;
          cnt_d   = CW'(1);
        end
      end
      S_MEASURE: begin
        if (pulse_s) begin
          // Counter saturates at the limit instead of wrapping.
          if (cnt_q < MAX_C) cnt_d = cnt_q + CW'(1);
          else               state_d = S_OVERFLOW;
        end else begin
          width_d = cnt_q;
          ovf_d   = 1'b0;
          match_d = (cnt_q == EXP_C);
          valid_d = 1'b1;
          state_d = S_REPORT;
        end
      end
      S_OVERFLOW: begin
        if (!pulse_s) begin
          width_d = MAX_C;
          ovf_d   = 1'b1;
          match_d = 1'b0;
          valid_d = 1'b1;
          state_d = S_REPORT;
        end
      end
      S_REPORT: begin
        // A rise here is lost even when it coincides with the ack.
        drop_d = rise;
        if (i_ack) begin
          valid_d = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        width_d = '0;
        valid_d = 1'b0;
        match_d = 1'b0;
        ovf_d   = 1'b0;
      end
    endcase
    // Busy is registered from the next state so it tracks the state with no output glitch.
    busy_d = (state_d == S_MEASURE) || (state_d == S_OVERFLOW);
  end

  // State and output registers; reset aborts any measurement in flight.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      width_q <= '0;
      valid_q <= 1'b0;
      match_q <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      width_q <= width_d;
      valid_q <= valid_d;
      match_q <= match_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      drop_q  <= drop_d;
    end
  end

  assign o_valid = valid_q;
  assign o_width = width_q;
  assign o_match = match_q;
  assign o_ovf   = ovf_q;
  assign o_busy  = busy_q;
  assign o_drop  = drop_q;

endmodule

// File: tb/tb_one_shot_pulse_rx.sv
// Bench for one_shot_pulse_rx: directed pulses, expected results queued and checked by a monitor.
module tb_one_shot_pulse_rx;

`ifdef PULSE_RX_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif
  localparam int CW = 5;

  logic          i_clk = 1'b0;
  logic          i_rst = 1'b1;
  logic          i_pulse = 1'b0;
  logic          i_ack = 1'b0;
  logic          o_valid;
  logic [CW-1:0] o_width;
  logic          o_match;
  logic          o_ovf;
  logic          o_busy;
  logic          o_drop;

  one_shot_pulse_rx #(.p_EXP_LENGTH(5), .p_MAX_LENGTH(16)) dut (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_pulse(i_pulse),
    .i_ack  (i_ack),
    .o_valid(o_valid),
    .o_width(o_width),
    .o_match(o_match),
    .o_ovf  (o_ovf),
    .o_busy (o_busy),
    .o_drop (o_drop)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    int width;
    int match;
    int ovf;
    int vcyc;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  int   busy_cycles = 0;
  int   drop_cycles = 0;
  logic vprev = 1'b0;

  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops an expected result on each new o_valid and checks it stays frozen.
  always @(negedge i_clk) begin
    if (o_valid && !vprev) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_result: width %0d reported with nothing expected (cycle %0d)", o_width, cyc);
      end else begin
        cur = sb.pop_front();
        check("res_width", int'(o_width), cur.width);
        check("res_match", int'(o_match), cur.match);
        check("res_ovf", int'(o_ovf), cur.ovf);
        check("res_cycle", cyc, cur.vcyc);
      end
    end else if (o_valid) begin
      check("hold_width", int'(o_width), cur.width);
      check("hold_match", int'(o_match), cur.match);
    end
    vprev = o_valid;
    if (o_busy) busy_cycles++;
    if (o_drop) drop_cycles++;
  end

  // Drive a pulse high for n sampled edges; optionally queue its expected result.
  task automatic pulse(input int n, input bit push, input int w, input int m, input int o);
    exp_t e;
    @(negedge i_clk);
    if (push) begin
      e.width = w;
      e.match = m;
      e.ovf   = o;
      e.vcyc  = cyc + 1 + n + LAT;
      sb.push_back(e);
    end
    i_pulse = 1'b1;
    repeat (n) @(negedge i_clk);
    i_pulse = 1'b0;
  endtask

  task automatic wait_valid();
    int t = 0;
    while (!o_valid && t < 200) begin
      @(negedge i_clk);
      t++;
    end
    check("valid_seen", int'(o_valid), 1);
  endtask

  task automatic do_ack();
    @(negedge i_clk);
    i_ack = 1'b1;
    @(negedge i_clk);
    i_ack = 1'b0;
    check("valid_clear", int'(o_valid), 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, int'(o_valid), 0);
    check({tag, "_width"}, int'(o_width), 0);
    check({tag, "_match"}, int'(o_match), 0);
    check({tag, "_ovf"}, int'(o_ovf), 0);
    check({tag, "_busy"}, int'(o_busy), 0);
    check({tag, "_drop"}, int'(o_drop), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset, with the pulse held high across release when no synchronizer is present.
    i_pulse = (LAT == 0);
    repeat (3) @(negedge i_clk);
    check_all_zero("rst");
    i_rst = 1'b0;
    repeat (3) @(negedge i_clk);
    check("no_rise_busy", int'(o_busy), 0);
    check("no_rise_valid", int'(o_valid), 0);
    i_pulse = 1'b0;
    pulse(4, 1'b1, 4, 0, 0);
    wait_valid();
    do_ack();

    // Nominal 5-cycle pulse, ack three cycles after valid.
    pulse(5, 1'b1, 5, 1, 0);
    wait_valid();
    repeat (3) @(negedge i_clk);
    check("held_valid", int'(o_valid), 1);
    do_ack();

    // Short pulses: 3 cycles then the 1-cycle minimum.
    pulse(3, 1'b1, 3, 0, 0);
    wait_valid();
    do_ack();
    pulse(1, 1'b1, 1, 0, 0);
    wait_valid();
    do_ack();

    // Overflow: 20-cycle pulse saturates at 16.
    @(negedge i_clk);
    busy_cycles = 0;
    pulse(20, 1'b1, 16, 0, 1);
    wait_valid();
    check("ovf_busy_cycles", busy_cycles, 20);
    do_ack();

    // Drops: unacked result, a 2-cycle pulse, then a rise coincident with ack.
    @(negedge i_clk);
    drop_cycles = 0;
    pulse(5, 1'b1, 5, 1, 0);
    wait_valid();
    pulse(2, 1'b0, 0, 0, 0);
    @(negedge i_clk);
    i_pulse = 1'b1;
    repeat (LAT) @(negedge i_clk);
    i_ack = 1'b1;
    @(negedge i_clk);
    i_ack = 1'b0;
    check("ack_rise_valid", int'(o_valid), 0);
    repeat (3) @(negedge i_clk);
    i_pulse = 1'b0;
    repeat (4 + LAT) @(negedge i_clk);
    check("drop_cycles", drop_cycles, 2);
    check("idle_busy", int'(o_busy), 0);
    check("idle_valid", int'(o_valid), 0);
    pulse(5, 1'b1, 5, 1, 0);
    wait_valid();
    do_ack();

    // Reset asserted in the third cycle of a pulse aborts it.
    @(negedge i_clk);
    i_pulse = 1'b1;
    repeat (2) @(negedge i_clk);
    i_rst = 1'b1;
    @(negedge i_clk);
    check_all_zero("midrst");
    i_pulse = 1'b0;
    @(negedge i_clk);
    i_rst = 1'b0;
    repeat (3 + LAT) @(negedge i_clk);
    check("post_rst_busy", int'(o_busy), 0);
    check("post_rst_valid", int'(o_valid), 0);
    pulse(6, 1'b1, 6, 0, 0);
    wait_valid();
    do_ack();

    repeat (5) @(negedge i_clk);
    check("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
